// File: rtl/c3_pkg.sv
// Shared constants and types for the C3 heap custom-instruction unit.
package c3_pkg;

    localparam int XLEN         = 32;
    localparam int C3_HEAP_SIZE = 32;
    localparam int HEAP_CAP     = C3_HEAP_SIZE - 1;

    // rd field of a command: zero means push, anything else is a pop target.
    localparam logic [4:0] C3_RD_PUSH = 5'd0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_WAIT   = 2'd2
    } c3_state_e;

endpackage

// File: rtl/c3_issue_queue_if.sv
// Command bus from the core and issue bus towards the heap.
interface c3_issue_queue_if
    import c3_pkg::*;
#(
    parameter int XLEN = c3_pkg::XLEN
);
    logic            cmd_v;
    logic [4:0]      cmd_rd;
    logic [XLEN-1:0] cmd_data;
    logic            cmd_ready;

    logic            hp_v;
    logic [4:0]      hp_rd;
    logic [XLEN-1:0] hp_data;
    logic            hp_busy;

    // Environment side: core dispatch plus the heap's busy flag.
    modport master (
        output cmd_v, cmd_rd, cmd_data, hp_busy,
        input  cmd_ready, hp_v, hp_rd, hp_data
    );

    // Issue queue side.
    modport slave (
        input  cmd_v, cmd_rd, cmd_data, hp_busy,
        output cmd_ready, hp_v, hp_rd, hp_data
    );
endinterface

// File: rtl/c3_cmd_fifo.sv
// Small synchronous command FIFO with a fall-through head (read data is
// combinational from the read pointer, so the head is visible the cycle
// after it is written).
module c3_cmd_fifo
    import c3_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 5 + c3_pkg::XLEN
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;

    // Extra pointer bit distinguishes full from empty when indices match.
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty   = (wptr == rptr);
    assign rd_data = mem[rptr[AW-1:0]];

    // Pointer update; push and pop in the same cycle both take effect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en && !full) wptr <= wptr + 1'b1;
            if (rd_en && !empty) rptr <= rptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because the pointers gate them.
    always_ff @(posedge clk) begin
        if (wr_en && !full) mem[wptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/c3_issue_queue.sv
// Issue stage in front of the C3 heap: buffers push/pop commands, issues
// them one at a time around the heap's registered busy flag, and resolves
// pops on an empty heap and pushes on a full heap locally using a shadow
// element count.
module c3_issue_queue
    import c3_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int HEAP_SIZE = c3_pkg::C3_HEAP_SIZE,
    parameter int XLEN      = c3_pkg::XLEN
) (
    input  logic                         clk,
    input  logic                         reset,
    c3_issue_queue_if.slave              bus,
    output logic                         byp_v,
    output logic [4:0]                   byp_rd,
    output logic [XLEN-1:0]              byp_data,
    output logic [$clog2(HEAP_SIZE)-1:0] occ,
    output logic [15:0]                  drop_cnt
);
    localparam int             OW      = $clog2(HEAP_SIZE);
    localparam logic [OW-1:0]  OCC_CAP = OW'(HEAP_SIZE - 1);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    c3_state_e         state, state_nxt;
    logic [XLEN+4:0]   head;
    logic [4:0]        head_rd;
    logic [XLEN-1:0]   head_data;
    logic              fifo_full, fifo_empty;
    logic              deq, do_issue, do_drop, do_byp;
    logic              hp_v_q;
    logic [4:0]        hp_rd_q;
    logic [XLEN-1:0]   hp_data_q;

    c3_cmd_fifo #(.DEPTH(DEPTH), .W(XLEN + 5)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (bus.cmd_v),
        .wr_data ({bus.cmd_rd, bus.cmd_data}),
        .rd_en   (deq),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign head_rd       = head[XLEN+4:XLEN];
    assign head_data     = head[XLEN-1:0];
    assign bus.cmd_ready = !fifo_full;
    assign bus.hp_v      = hp_v_q;
    assign bus.hp_rd     = hp_rd_q;
    assign bus.hp_data   = hp_data_q;
    assign byp_data      = '0;

    // Issue FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state and per-cycle decision: issue, drop, bypass, or hold.
    always_comb begin
        state_nxt = state;
        deq       = 1'b0;
        do_issue  = 1'b0;
        do_drop   = 1'b0;
        do_byp    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty && !bus.hp_busy) begin
                    deq = 1'b1;
                    if (head_rd == C3_RD_PUSH) begin
                        if (occ < OCC_CAP) begin
                            do_issue  = 1'b1;
                            state_nxt = ST_SETTLE;
                        end else begin
                            do_drop = 1'b1;
                        end
                    end else begin
                        if (occ != '0) begin
                            do_issue  = 1'b1;
                            state_nxt = ST_SETTLE;
                        end else begin
                            do_byp = 1'b1;
                        end
                    end
                end
            end
            // Heap busy is registered, so it is not meaningful until the
            // cycle after the issue strobe.
            ST_SETTLE: state_nxt = ST_WAIT;
            ST_WAIT:   if (!bus.hp_busy) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Registered outputs, shadow occupancy and drop counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hp_v_q    <= 1'b0;
            hp_rd_q   <= '0;
            hp_data_q <= '0;
            byp_v     <= 1'b0;
            byp_rd    <= '0;
            occ       <= '0;
            drop_cnt  <= '0;
        end else begin
            hp_v_q <= do_issue;
            byp_v  <= do_byp;
            if (do_issue) begin
                hp_rd_q   <= head_rd;
                hp_data_q <= head_data;
                occ       <= (head_rd == C3_RD_PUSH) ? occ + 1'b1 : occ - 1'b1;
            end
            if (do_byp)  byp_rd   <= head_rd;
            if (do_drop) drop_cnt <= sat_inc16(drop_cnt);
        end
    end

endmodule

// File: tb/tb_c3_issue_queue.sv
// Scoreboard bench for c3_issue_queue: a command-level model predicts which
// commands reach the heap and which are resolved locally, and a monitor
// compares every hp_v / byp_v pulse against those predictions in order.
module tb_c3_issue_queue;
    import c3_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    c3_issue_queue_if #(.XLEN(32)) bus ();

    logic        byp_v;
    logic [4:0]  byp_rd;
    logic [31:0] byp_data;
    logic [4:0]  occ;
    logic [15:0] drop_cnt;

    logic busy_gen = 1'b0;
    logic force_busy = 1'b0;
    assign bus.hp_busy = busy_gen | force_busy;

    c3_issue_queue #(.DEPTH(4), .HEAP_SIZE(32), .XLEN(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .byp_v    (byp_v),
        .byp_rd   (byp_rd),
        .byp_data (byp_data),
        .occ      (occ),
        .drop_cnt (drop_cnt)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_iss = -1;

    logic [36:0] exp_iss[$];
    logic [4:0]  exp_byp[$];
    int          m_occ = 0;
    int          m_drop = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Reference model: the heap's element count depends only on the order of
    // accepted commands, so each accepted command's fate is known at once.
    function automatic void model_accept(input logic [4:0] rd, input logic [31:0] d);
        if (rd == 5'd0) begin
            if (m_occ < 31) begin
                exp_iss.push_back({rd, d});
                m_occ++;
            end else if (m_drop < 65535) begin
                m_drop++;
            end
        end else begin
            if (m_occ > 0) begin
                exp_iss.push_back({rd, d});
                m_occ--;
            end else begin
                exp_byp.push_back(rd);
            end
        end
    endfunction

    // Called in the negedge phase; returns in the negedge phase after acceptance.
    task automatic send(input logic [4:0] rd, input logic [31:0] d);
        logic r;
        int   n;
        bit   done;
        n = 0;
        done = 0;
        bus.cmd_v = 1'b1;
        bus.cmd_rd = rd;
        bus.cmd_data = d;
        while (!done) begin
            r = bus.cmd_ready;
            @(posedge clk);
            if (r) begin
                model_accept(rd, d);
                done = 1;
            end else if (n > 400) begin
                chk("send_timeout", 64'(0), 64'(1));
                done = 1;
            end
            n++;
            @(negedge clk);
        end
        bus.cmd_v = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_iss.size() != 0 || exp_byp.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("drain_timeout", 64'(0), 64'(1));
        repeat (12) @(negedge clk);
    endtask

    // Heap busy model: registered busy raised after each issue for a few cycles.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reset && bus.hp_v) begin
                busy_gen = 1'b1;
                repeat ($urandom_range(4, 1)) @(posedge clk);
                #1 busy_gen = 1'b0;
            end
        end
    end

    // Monitor: compare every output event against the head of its queue.
    initial begin
        logic [36:0] e;
        logic [4:0]  eb;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                last_iss = -1;
            end else begin
                if (bus.hp_v) begin
                    if (exp_iss.size() == 0) begin
                        chk("hp_v_unexpected", 64'(1), 64'(0));
                    end else begin
                        e = exp_iss.pop_front();
                        chk("hp_rd", 64'(bus.hp_rd), 64'(e[36:32]));
                        if (e[36:32] == 5'd0) chk("hp_data", 64'(bus.hp_data), 64'(e[31:0]));
                    end
                    if (last_iss >= 0) chk("issue_spacing_ge3", 64'(cyc - last_iss >= 3), 64'(1));
                    last_iss = cyc;
                end
                if (byp_v) begin
                    if (exp_byp.size() == 0) begin
                        chk("byp_v_unexpected", 64'(1), 64'(0));
                    end else begin
                        eb = exp_byp.pop_front();
                        chk("byp_rd", 64'(byp_rd), 64'(eb));
                        chk("byp_data", 64'(byp_data), 64'(0));
                    end
                    chk("byp_hp_overlap", 64'(bus.hp_v), 64'(0));
                end
            end
        end
    end

    initial begin
        int c0;
        logic [4:0] rd;
        bus.cmd_v = 1'b0;
        bus.cmd_rd = '0;
        bus.cmd_data = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_hp_v", 64'(bus.hp_v), 64'(0));
        chk("rst_hp_rd", 64'(bus.hp_rd), 64'(0));
        chk("rst_hp_data", 64'(bus.hp_data), 64'(0));
        chk("rst_byp_v", 64'(byp_v), 64'(0));
        chk("rst_byp_rd", 64'(byp_rd), 64'(0));
        chk("rst_occ", 64'(occ), 64'(0));
        chk("rst_drop", 64'(drop_cnt), 64'(0));
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
        reset = 1'b1;
        @(negedge clk);

        // Push 5, push 9, pop rd=3
        send(5'd0, 32'd5);
        send(5'd0, 32'd9);
        send(5'd3, 32'd0);
        drain();
        chk("t1_occ", 64'(occ), 64'(1));

        // Empty the heap, then pop on empty resolves locally one cycle later
        send(5'd4, 32'd0);
        drain();
        chk("t2_occ0", 64'(occ), 64'(0));
        send(5'd7, 32'hDEAD);
        @(negedge clk);
        chk("t2_byp_latency", 64'(byp_v), 64'(1));
        drain();

        // Fill the heap and overflow it by one
        for (int i = 1; i <= 31; i++) send(5'd0, 32'(i));
        send(5'd0, 32'd100);
        drain();
        chk("t3_occ_full", 64'(occ), 64'(31));
        chk("t3_drop", 64'(drop_cnt), 64'(1));

        // Back-to-back pushes against a held busy
        for (int i = 1; i <= 8; i++) send(5'(i), 32'd0);
        drain();
        chk("t4_occ_pre", 64'(occ), 64'(23));
        force_busy = 1'b1;
        @(negedge clk);
        c0 = cyc;
        for (int i = 0; i < 4; i++) send(5'd0, 32'h100 + 32'(i));
        chk("t4_fifo_full", 64'(bus.cmd_ready), 64'(0));
        fork
            begin
                send(5'd0, 32'h104);
                chk("t4_held_off", 64'(cyc - c0 >= 18), 64'(1));
                send(5'd0, 32'h105);
            end
            begin
                repeat (20) @(posedge clk);
                #1 force_busy = 1'b0;
            end
        join
        drain();
        chk("t4_occ", 64'(occ), 64'(29));

        // Randomized mix
        for (int i = 0; i < 300; i++) begin
            rd = ($urandom_range(1, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
            send(rd, $urandom);
            repeat ($urandom_range(2, 0)) @(negedge clk);
        end
        drain();
        chk("rand_occ", 64'(occ), 64'(m_occ));
        chk("rand_drop", 64'(drop_cnt), 64'(m_drop));

        // Asynchronous reset while waiting on the heap
        send(5'd0, 32'd42);
        begin
            int n;
            n = 0;
            while (!bus.hp_v && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("t5_issue_seen", 64'(bus.hp_v), 64'(1));
        end
        force_busy = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
        force_busy = 1'b0;
        exp_iss.delete();
        exp_byp.delete();
        m_occ = 0;
        m_drop = 0;
        #1;
        chk("t5_hp_v", 64'(bus.hp_v), 64'(0));
        chk("t5_hp_rd", 64'(bus.hp_rd), 64'(0));
        chk("t5_hp_data", 64'(bus.hp_data), 64'(0));
        chk("t5_byp_v", 64'(byp_v), 64'(0));
        chk("t5_occ", 64'(occ), 64'(0));
        chk("t5_drop", 64'(drop_cnt), 64'(0));
        chk("t5_cmd_ready", 64'(bus.cmd_ready), 64'(1));
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        send(5'd1, 32'd0);
        drain();
        chk("t5_occ_after", 64'(occ), 64'(0));
        chk("t5_byp_consumed", 64'(exp_byp.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
